// File: rtl/isp_param_controller.sv
// rtl/isp_param_controller.sv - button arbitration, debounce and vsync-committed level registers for the gamma/bright/contrast stages
module isp_param_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LEVEL_W         = 3,
    parameter int LEVEL_MAX       = 7,
    parameter int GAMMA_DEF       = 3,
    parameter int BRIGHT_DEF      = 4,
    parameter int CONTRAST_DEF    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         btn,
    input  logic               gamma_sw,
    input  logic               bright_sw,
    input  logic               contrast_sw,
    input  logic               vsync,
    output logic [LEVEL_W-1:0] gamma_level,
    output logic [LEVEL_W-1:0] bright_level,
    output logic [LEVEL_W-1:0] contrast_level,
    output logic [1:0]         active_mode,
    output logic               pending,
    output logic               mode_conflict
);

    localparam int CNT_W = (DEBOUNCE_CYCLES >= 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LVL_ZERO = '0;
    localparam logic [LEVEL_W-1:0] LVL_DEF [3] = '{LEVEL_W'(GAMMA_DEF), LEVEL_W'(BRIGHT_DEF), LEVEL_W'(CONTRAST_DEF)};

    localparam logic [1:0] MODE_NONE     = 2'd0;
    localparam logic [1:0] MODE_GAMMA    = 2'd1;
    localparam logic [1:0] MODE_BRIGHT   = 2'd2;
    localparam logic [1:0] MODE_CONTRAST = 2'd3;

    logic [1:0]         btn_meta_q, btn_sync_q;
    logic [CNT_W-1:0]   cnt_q [2];
    logic [CNT_W-1:0]   cnt_d [2];
    logic [1:0]         acc_q, acc_d, acc_prev_q;
    logic [1:0]         press_q;
    logic [1:0]         active_mode_q, mode_d;
    logic               conflict_q, conflict_d;
    logic               lockout_q, lockout_d;
    logic               vsync_prev_q, vs_fall_q;
    logic [LEVEL_W-1:0] shadow_q [3];
    logic [LEVEL_W-1:0] shadow_d [3];
    logic [LEVEL_W-1:0] live_q [3];
    logic               pending_q, pending_d;
    logic               evt_ok, restore;

    // Two-flop synchroniser for the raw asynchronous buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            btn_meta_q <= btn;
            btn_sync_q <= btn_meta_q;
        end
    end

    // Debounce: count consecutive cycles of disagreement, accept the new level after DEBOUNCE_CYCLES
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            acc_d[i] = acc_q[i];
            cnt_d[i] = '0;
            if (btn_sync_q[i] != acc_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    acc_d[i] = btn_sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce state and one-cycle press pulse on a rising accepted level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            acc_q      <= '0;
            acc_prev_q <= '0;
            press_q    <= '0;
        end else begin
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            acc_q      <= acc_d;
            acc_prev_q <= acc_q;
            press_q    <= acc_q & ~acc_prev_q;
        end
    end

    // Fixed-priority stage selection; lockout holds off events until both buttons are released after a mode change
    always_comb begin
        mode_d = MODE_NONE;
        if (gamma_sw) begin
            mode_d = MODE_GAMMA;
        end else if (bright_sw) begin
            mode_d = MODE_BRIGHT;
        end else if (contrast_sw) begin
            mode_d = MODE_CONTRAST;
        end
        conflict_d = (gamma_sw & bright_sw) | (gamma_sw & contrast_sw) | (bright_sw & contrast_sw);
        lockout_d  = lockout_q;
        if (mode_d != active_mode_q) begin
            lockout_d = 1'b1;
        end else if (acc_q == 2'b00) begin
            lockout_d = 1'b0;
        end
    end

    // Mode, conflict and lockout registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_mode_q <= MODE_NONE;
            conflict_q    <= 1'b0;
            lockout_q     <= 1'b0;
        end else begin
            active_mode_q <= mode_d;
            conflict_q    <= conflict_d;
            lockout_q     <= lockout_d;
        end
    end

    // Shadow update: saturating step, or restore to default when the buttons are combined
    always_comb begin
        evt_ok  = (press_q != 2'b00) && !lockout_q && (active_mode_q != MODE_NONE);
        restore = (press_q[0] & press_q[1]) | (press_q[0] & acc_q[1]) | (press_q[1] & acc_q[0]);
        for (int k = 0; k < 3; k++) begin
            shadow_d[k] = shadow_q[k];
            if (evt_ok && active_mode_q == 2'(k + 1)) begin
                if (restore) begin
                    shadow_d[k] = LVL_DEF[k];
                end else if (press_q[0]) begin
                    if (shadow_q[k] < LVL_MAX) begin
                        shadow_d[k] = shadow_q[k] + LEVEL_W'(1);
                    end
                end else if (shadow_q[k] != LVL_ZERO) begin
                    shadow_d[k] = shadow_q[k] - LEVEL_W'(1);
                end
            end
        end
        pending_d = (shadow_q[0] != live_q[0]) | (shadow_q[1] != live_q[1]) | (shadow_q[2] != live_q[2]);
    end

    // Shadow/live registers; live copies shadow one cycle after a registered vsync fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_prev_q <= 1'b1;
            vs_fall_q    <= 1'b0;
            pending_q    <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                shadow_q[k] <= LVL_DEF[k];
                live_q[k]   <= LVL_DEF[k];
            end
        end else begin
            vsync_prev_q <= vsync;
            vs_fall_q    <= vsync_prev_q & ~vsync;
            pending_q    <= pending_d;
            for (int k = 0; k < 3; k++) begin
                shadow_q[k] <= shadow_d[k];
                if (vs_fall_q) begin
                    live_q[k] <= shadow_q[k];
                end
            end
        end
    end

    assign gamma_level    = live_q[0];
    assign bright_level   = live_q[1];
    assign contrast_level = live_q[2];
    assign active_mode    = active_mode_q;
    assign pending        = pending_q;
    assign mode_conflict  = conflict_q;

endmodule
